// File: rtl/div_pkg.sv
`default_nettype none
// ============================================================================
// Module   : div_pkg
// Purpose  : Shared constants for the sequential divider (and the booth
//            multiplier beside it): FSM state encodings and default widths.
// Contents : c_DEF_N  - default divisor/quotient/remainder width
//            c_DEF_CW - default step-counter width, clog2(c_DEF_N)+1
//            c_IDLE / c_ITER / c_CORR / c_DONE - 2-bit state codes
// Revision : 1.0 - initial release
// ============================================================================
package div_pkg;

    localparam int c_DEF_N  = 8;
    localparam int c_DEF_CW = 4;

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_ITER = 2'd1;
    localparam logic [1:0] c_CORR = 2'd2;
    localparam logic [1:0] c_DONE = 2'd3;

endpackage : div_pkg
`default_nettype wire

// File: rtl/div_sign_fix.sv
`default_nettype none
// ============================================================================
// Module   : div_sign_fix
// Purpose  : Combinational conditional two's-complement negation. With
//            i_neg tied to the operand's sign bit it yields the magnitude;
//            with i_neg as a result sign it applies the sign fix-up.
// Ports    : i_val [W-1:0] - value in
//            i_neg         - 1: output the negation of i_val
//            o_val [W-1:0] - value out
// Revision : 1.0 - initial release
// ============================================================================
module div_sign_fix #(
    parameter int W = 8
) (
    input  logic [W-1:0] i_val,
    input  logic         i_neg,
    output logic [W-1:0] o_val
);

    // The most negative value maps onto itself, which read as unsigned is
    // exactly its magnitude.
    assign o_val = i_neg ? ({W{1'b0}} - i_val) : i_val;

endmodule : div_sign_fix
`default_nettype wire

// File: rtl/nonrestoring_divider.sv
`default_nettype none
// ============================================================================
// Module   : nonrestoring_divider
// Purpose  : Sequential signed divider, 2N-bit dividend by N-bit divisor.
//            Radix-2 non-restoring core on magnitudes, one quotient bit per
//            clock, followed by a single correction/sign fix-up cycle.
// Ports    : clk, rst (sync, active high)
//            start                 - request, sampled only in IDLE
//            dividend [2N-1:0]     - signed, sampled with start
//            divisor  [N-1:0]      - signed, sampled with start
//            quotient [N-1:0]      - signed, truncated toward zero
//            remainder[N-1:0]      - signed, sign follows dividend
//            busy                  - operation in progress
//            done                  - one-cycle result-valid pulse
//            div_by_zero, overflow - status flags, valid with done
//            u [CW-1:0]            - iteration count (debug)
// Revision : 1.0 - initial release
// ============================================================================
module nonrestoring_divider
    import div_pkg::*;
#(
    parameter int N  = c_DEF_N,
    parameter int CW = c_DEF_CW
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2*N-1:0]   dividend,
    input  logic [N-1:0]     divisor,
    output logic [N-1:0]     quotient,
    output logic [N-1:0]     remainder,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic             overflow,
    output logic [CW-1:0]    u
);

    localparam logic [N-1:0]  c_HALF    = {1'b1, {(N-1){1'b0}}};
    localparam logic [CW-1:0] c_LAST_M1 = CW'(N - 1);

    logic [1:0]     r_state;
    logic [N:0]     r_p;        // signed partial remainder
    logic [N-1:0]   r_a;        // dividend low half, becomes quotient magnitude
    logic [N-1:0]   r_v;        // divisor magnitude
    logic           r_sgn_dd;
    logic           r_sgn_dv;

    logic [2*N-1:0] w_dd_mag;
    logic [N-1:0]   w_dv_mag;
    logic [N:0]     w_p_sh;
    logic [N:0]     w_p_step;
    logic [N-1:0]   w_rem_mag;
    logic           w_q_neg;
    logic           w_q_ovf;
    logic [N-1:0]   w_q_fix;
    logic [N-1:0]   w_r_fix;

    div_sign_fix #(.W(2*N)) u_abs_dd (
        .i_val (dividend),
        .i_neg (dividend[2*N-1]),
        .o_val (w_dd_mag)
    );

    div_sign_fix #(.W(N)) u_abs_dv (
        .i_val (divisor),
        .i_neg (divisor[N-1]),
        .o_val (w_dv_mag)
    );

    // |P| < V <= 2^(N-1) between steps, so P fits N signed bits and the
    // shifted value 2P+bit still fits the N+1-bit register.
    assign w_p_sh   = {r_p[N-1:0], r_a[N-1]};
    assign w_p_step = r_p[N] ? (w_p_sh + {1'b0, r_v}) : (w_p_sh - {1'b0, r_v});

    // Final restore of a negative partial remainder; result is below V.
    assign w_rem_mag = r_p[N] ? (r_p[N-1:0] + r_v) : r_p[N-1:0];

    assign w_q_neg = r_sgn_dd ^ r_sgn_dv;
    // Negative results may reach 2^(N-1); positive ones only 2^(N-1)-1.
    assign w_q_ovf = w_q_neg ? (r_a > c_HALF) : r_a[N-1];

    div_sign_fix #(.W(N)) u_fix_q (
        .i_val (r_a),
        .i_neg (w_q_neg),
        .o_val (w_q_fix)
    );

    div_sign_fix #(.W(N)) u_fix_r (
        .i_val (w_rem_mag),
        .i_neg (r_sgn_dd),
        .o_val (w_r_fix)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= c_IDLE;
            r_p         <= '0;
            r_a         <= '0;
            r_v         <= '0;
            r_sgn_dd    <= 1'b0;
            r_sgn_dv    <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            u           <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    if (start) begin
                        r_p         <= {1'b0, w_dd_mag[2*N-1:N]};
                        r_a         <= w_dd_mag[N-1:0];
                        r_v         <= w_dv_mag;
                        r_sgn_dd    <= dividend[2*N-1];
                        r_sgn_dv    <= divisor[N-1];
                        u           <= '0;
                        div_by_zero <= 1'b0;
                        overflow    <= 1'b0;
                        if (divisor == '0) begin
                            div_by_zero <= 1'b1;
                            quotient    <= '1;
                            remainder   <= dividend[N-1:0];
                            r_state     <= c_DONE;
                        end else if (w_dd_mag[2*N-1:N] >= w_dv_mag) begin
                            // Quotient magnitude cannot fit N bits.
                            overflow    <= 1'b1;
                            quotient    <= '0;
                            remainder   <= '0;
                            r_state     <= c_DONE;
                        end else begin
                            busy        <= 1'b1;
                            r_state     <= c_ITER;
                        end
                    end
                end
                c_ITER: begin
                    r_p <= w_p_step;
                    r_a <= {r_a[N-2:0], ~w_p_step[N]};
                    u   <= u + CW'(1);
                    if (u == c_LAST_M1) begin
                        r_state <= c_CORR;
                    end
                end
                c_CORR: begin
                    if (w_q_ovf) begin
                        overflow  <= 1'b1;
                        quotient  <= '0;
                        remainder <= '0;
                    end else begin
                        quotient  <= w_q_fix;
                        remainder <= w_r_fix;
                    end
                    r_state <= c_DONE;
                end
                c_DONE: begin
                    done    <= 1'b1;
                    busy    <= 1'b0;
                    r_state <= c_IDLE;
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

endmodule : nonrestoring_divider
`default_nettype wire

// File: tb/tb_nonrestoring_divider.sv
`default_nettype none
// ============================================================================
// Module   : tb_nonrestoring_divider
// Purpose  : Directed self-checking bench for nonrestoring_divider (N=8).
// Revision : 1.0 - initial release
// ============================================================================
module tb_nonrestoring_divider;

    localparam int N  = 8;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [2*N-1:0] dividend = '0;
    logic [N-1:0]  divisor = '0;
    logic [N-1:0]  quotient;
    logic [N-1:0]  remainder;
    logic          busy;
    logic          done;
    logic          div_by_zero;
    logic          overflow;
    logic [CW-1:0] u;

    int n_cmp = 0;
    int n_err = 0;

    nonrestoring_divider #(.N(N), .CW(CW)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .quotient    (quotient),
        .remainder   (remainder),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero),
        .overflow    (overflow),
        .u           (u)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge right after the accepting edge.
    task automatic pulse_start(input logic [2*N-1:0] dd, input logic [N-1:0] dv);
        dividend = dd;
        divisor  = dv;
        start    = 1'b1;
        @(negedge clk);
        start    = 1'b0;
    endtask

    // k counts clock edges since the accepting edge.
    task automatic wait_done(input int k0, output int k);
        k = k0;
        while (done !== 1'b1 && k < 40) begin
            @(negedge clk);
            k++;
        end
    endtask

    task automatic check_res(input string tag, input int k, input int ek,
                             input logic [N-1:0] eq, input logic [N-1:0] er,
                             input logic ebz, input logic eov, input logic [CW-1:0] eu);
        check_val({tag, ":latency"}, k, ek);
        check_val({tag, ":quotient"}, quotient, eq);
        check_val({tag, ":remainder"}, remainder, er);
        check_val({tag, ":div_by_zero"}, div_by_zero, ebz);
        check_val({tag, ":overflow"}, overflow, eov);
        check_val({tag, ":u"}, u, eu);
    endtask

    task automatic run_div(input string tag, input bit b2b,
                           input logic [2*N-1:0] dd, input logic [N-1:0] dv,
                           input int ek, input logic [N-1:0] eq, input logic [N-1:0] er,
                           input logic ebz, input logic eov, input logic [CW-1:0] eu);
        int k;
        if (!b2b) @(negedge clk);
        pulse_start(dd, dv);
        wait_done(0, k);
        check_res(tag, k, ek, eq, er, ebz, eov, eu);
    endtask

    initial begin
        int k;
        int seen;

        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_val("rst:quotient", quotient, 0);
        check_val("rst:remainder", remainder, 0);
        check_val("rst:busy", busy, 0);
        check_val("rst:done", done, 0);
        check_val("rst:flags", {div_by_zero, overflow}, 0);
        check_val("rst:u", u, 0);
        rst = 1'b0;

        // 225 / 15 with busy and done-pulse checks
        @(negedge clk);
        pulse_start(16'd225, 8'd15);
        check_val("div1:busy_on", busy, 1);
        wait_done(0, k);
        check_res("div1", k, 10, 8'd15, 8'd0, 1'b0, 1'b0, 4'd8);
        check_val("div1:busy_off", busy, 0);
        @(negedge clk);
        check_val("div1:done_pulse", done, 0);

        run_div("neg_dd",   1'b0, 16'hFFF9, 8'd2,   10, 8'hFD, 8'hFF, 1'b0, 1'b0, 4'd8);
        run_div("neg_dv",   1'b0, 16'd100,  8'hF9,  10, 8'hF2, 8'h02, 1'b0, 1'b0, 4'd8);
        run_div("ovf_late", 1'b0, 16'hC000, 8'h80,  10, 8'h00, 8'h00, 1'b0, 1'b1, 4'd8);
        // accepted in the IDLE cycle that carries done; flags must clear
        run_div("min_q_b2b", 1'b1, 16'hC080, 8'd127, 10, 8'h80, 8'h00, 1'b0, 1'b0, 4'd8);
        run_div("ovf_min",  1'b0, 16'h8000, 8'h80,   1, 8'h00, 8'h00, 1'b0, 1'b1, 4'd0);
        run_div("dbz",      1'b0, 16'd123,  8'd0,    1, 8'hFF, 8'h7B, 1'b1, 1'b0, 4'd0);
        run_div("ovf_early", 1'b0, 16'h4000, 8'd2,   1, 8'h00, 8'h00, 1'b0, 1'b1, 4'd0);

        // second start during the operation is ignored
        @(negedge clk);
        pulse_start(16'd225, 8'd15);
        repeat (2) @(negedge clk);
        dividend = 16'd100;
        divisor  = 8'd7;
        start    = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        wait_done(3, k);
        check_res("ign_start", k, 10, 8'd15, 8'd0, 1'b0, 1'b0, 4'd8);

        // reset in the middle of an operation
        @(negedge clk);
        pulse_start(16'hFFF9, 8'd2);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_val("mid_rst:quotient", quotient, 0);
        check_val("mid_rst:remainder", remainder, 0);
        check_val("mid_rst:busy", busy, 0);
        check_val("mid_rst:done", done, 0);
        check_val("mid_rst:u", u, 0);
        check_val("mid_rst:flags", {div_by_zero, overflow}, 0);
        rst = 1'b0;
        seen = 0;
        repeat (15) begin
            @(negedge clk);
            if (done === 1'b1) seen = 1;
        end
        check_val("mid_rst:no_done", seen, 0);
        run_div("after_rst", 1'b0, 16'd100, 8'hF9, 10, 8'hF2, 8'h02, 1'b0, 1'b0, 4'd8);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_nonrestoring_divider
`default_nettype wire
